stage_wb: RTL and testbench

//  Writeback/commit stage; consumes the MEM stage outputs through mem_out_if.other, with no extra register slice.

---
 rtl/br32_pkg.sv | 30 +++
 rtl/mem_out_if.sv | 24 ++
 rtl/wb_sr_file.sv | 101 ++++++++++
 rtl/stage_wb.sv | 114 +++++++++++
 tb/tb_stage_wb.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/br32_pkg.sv
// rtl/br32_pkg.sv - shared SR indices, trap cause codes and writeback FSM state
// Purpose: constants and types shared by the writeback stage and its SR file.
// Ports: none (package).
package br32_pkg;

    localparam logic [3:0] SR_EPC     = 4'd0;
    localparam logic [3:0] SR_CAUSE   = 4'd1;
    localparam logic [3:0] SR_EVEC    = 4'd2;
    localparam logic [3:0] SR_SCRATCH = 4'd3;
    localparam logic [3:0] SR_CYCLE   = 4'd4;
    localparam logic [3:0] SR_INSTRET = 4'd5;

    localparam logic [1:0] CAUSE_SCALL = 2'd1;
    localparam logic [1:0] CAUSE_UDF   = 2'd2;
    localparam logic [1:0] CAUSE_ERET  = 2'd3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        TRAP = 2'd1,
        HALT = 2'd2
    } wb_state_t;

    // scall wins over udf; anything else that traps is an eret outside a handler
    function automatic logic [1:0] trap_cause(input logic scall, input logic udf);
        if (scall)    return CAUSE_SCALL;
        else if (udf) return CAUSE_UDF;
        else          return CAUSE_ERET;
    endfunction

endpackage

// File: rtl/mem_out_if.sv
// rtl/mem_out_if.sv - MEM stage result bundle consumed by writeback
// Purpose: carries one retiring instruction from MEM to WB.
// Ports: none; modport mem drives the bundle, modport other consumes it.
interface mem_out_if;
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic [31:0] alu_res;
    logic [31:0] op3;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        w_rd;
    logic [1:0]  cmp_res;
    logic        w_cr;
    logic        mtsr;
    logic        scall;
    logic        eret;
    logic        udf;
    logic        bubble;

    modport mem (output pc, nextpc, alu_res, op3, res, rd, w_rd, cmp_res, w_cr,
                        mtsr, scall, eret, udf, bubble);
    modport other (input pc, nextpc, alu_res, op3, res, rd, w_rd, cmp_res, w_cr,
                         mtsr, scall, eret, udf, bubble);
endinterface

// File: rtl/wb_sr_file.sv
// rtl/wb_sr_file.sv - system register storage, read mux and perf counters
// Purpose: holds EPC/CAUSE/EVEC/SCRATCH (+ CYCLE/INSTRET when BR32_PERF_CNT_EN).
// Ports: clk_i, rst_i; raddr_i/rdata_o read port; mtsr_we_i/waddr_i/wdata_i
//        software write; trap_we_i/epc_i/cause_i trap capture;
//        cycle_inc_i/instret_inc_i counter strobes; epc_o/evec_o to the FSM.
module wb_sr_file
    import br32_pkg::*;
#(
    parameter logic [31:0] EVEC_RST = 32'h0000_0100,
    parameter int          SR_AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SR_AW-1:0] raddr_i,
    output logic [31:0]      rdata_o,
    input  logic             mtsr_we_i,
    input  logic [SR_AW-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    input  logic             trap_we_i,
    input  logic [31:0]      epc_i,
    input  logic [1:0]       cause_i,
    input  logic             cycle_inc_i,
    input  logic             instret_inc_i,
    output logic [31:0]      epc_o,
    output logic [31:0]      evec_o
);

    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] evec_q, evec_d;
    logic [31:0] scratch_q, scratch_d;

    // CAUSE is only written by trap capture; software writes to it are dropped
    always_comb begin
        epc_d     = epc_q;
        cause_d   = cause_q;
        evec_d    = evec_q;
        scratch_d = scratch_q;
        if (trap_we_i) begin
            epc_d   = epc_i;
            cause_d = cause_i;
        end else if (mtsr_we_i) begin
            case (waddr_i)
                SR_AW'(SR_EPC):     epc_d     = wdata_i;
                SR_AW'(SR_EVEC):    evec_d    = wdata_i;
                SR_AW'(SR_SCRATCH): scratch_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            epc_q     <= '0;
            cause_q   <= '0;
            evec_q    <= EVEC_RST;
            scratch_q <= '0;
        end else begin
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            evec_q    <= evec_d;
            scratch_q <= scratch_d;
        end
    end

`ifdef BR32_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (cycle_inc_i)   cycle_q   <= cycle_q + 32'd1;
            if (instret_inc_i) instret_q <= instret_q + 32'd1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^{cycle_inc_i, instret_inc_i};
`endif

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            SR_AW'(SR_EPC):     rdata_o = epc_q;
            SR_AW'(SR_CAUSE):   rdata_o = {30'd0, cause_q};
            SR_AW'(SR_EVEC):    rdata_o = evec_q;
            SR_AW'(SR_SCRATCH): rdata_o = scratch_q;
`ifdef BR32_PERF_CNT_EN
            SR_AW'(SR_CYCLE):   rdata_o = cycle_q;
            SR_AW'(SR_INSTRET): rdata_o = instret_q;
`endif
            default:            rdata_o = '0;
        endcase
    end

    assign epc_o  = epc_q;
    assign evec_o = evec_q;

endmodule

// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - writeback/commit stage with trap FSM
// Purpose: commits GPR/cmp_reg/SR writes from MEM, raises exn and redirects on
//          traps, halts on a double fault. Optional perf counters: BR32_PERF_CNT_EN.
// Ports: clk, rst (async, active-high); MEM (mem_out_if.other);
//        rf_we/rf_waddr/rf_wdata GPR write; cmp_reg, scr compare flags;
//        sr_rdata SR read data; exn/exn_pc flush and redirect; halted.
module stage_wb
    import br32_pkg::*;
#(
    parameter logic [31:0] EVEC_RST = 32'h0000_0100,
    parameter int          SR_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    mem_out_if.other    MEM,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  cmp_reg,
    output logic [1:0]  scr,
    output logic [31:0] sr_rdata,
    output logic        exn,
    output logic [31:0] exn_pc,
    output logic        halted
);

    wb_state_t   state_q;
    logic        halted_q;
    logic [1:0]  cmp_reg_q;
    logic [1:0]  scr_q;

    logic        in_halt;
    logic        trap;
    logic        eret_ok;
    logic        commit;
    logic [31:0] epc;
    logic [31:0] evec;

    always_comb begin
        in_halt = (state_q == HALT);
        // eret inside a handler is a return, eret in RUN is itself a trap
        trap    = !in_halt && (MEM.scall || MEM.udf || (MEM.eret && state_q == RUN));
        eret_ok = (state_q == TRAP) && MEM.eret && !MEM.scall && !MEM.udf;
        commit  = !in_halt && !trap;
        exn     = in_halt || trap || eret_ok;
        // only a fresh trap from RUN vectors; returns and halt replay EPC
        exn_pc  = (state_q == RUN) ? evec : epc;
        rf_we   = commit && MEM.w_rd && (MEM.rd != 5'd0);
    end

    assign rf_waddr = MEM.rd;
    assign rf_wdata = MEM.res;
    assign cmp_reg  = cmp_reg_q;
    assign scr      = scr_q;
    assign halted   = halted_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            halted_q  <= 1'b0;
            cmp_reg_q <= '0;
            scr_q     <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (trap) begin
                        scr_q   <= cmp_reg_q;
                        state_q <= TRAP;
                    end
                end
                TRAP: begin
                    if (MEM.scall || MEM.udf) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else if (MEM.eret) begin
                        state_q <= RUN;
                    end
                end
                HALT: ;
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
            // the handler-exit eret is a commit, so its cmp_reg restore lands here
            if (commit && MEM.w_cr) cmp_reg_q <= MEM.cmp_res;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{MEM.alu_res[31:SR_AW]};

    wb_sr_file #(
        .EVEC_RST (EVEC_RST),
        .SR_AW    (SR_AW)
    ) u_sr_file (
        .clk_i         (clk),
        .rst_i         (rst),
        .raddr_i       (MEM.alu_res[SR_AW-1:0]),
        .rdata_o       (sr_rdata),
        .mtsr_we_i     (commit && MEM.mtsr),
        .waddr_i       (MEM.alu_res[SR_AW-1:0]),
        .wdata_i       (MEM.op3),
        // a double fault keeps the first trap's EPC/CAUSE
        .trap_we_i     (trap && state_q == RUN),
        .epc_i         (MEM.scall ? MEM.nextpc : MEM.pc),
        .cause_i       (trap_cause(MEM.scall, MEM.udf)),
        .cycle_inc_i   (!in_halt),
        .instret_inc_i (commit && !MEM.bubble),
        .epc_o         (epc),
        .evec_o        (evec)
    );

endmodule

// File: tb/tb_stage_wb.sv
// tb/tb_stage_wb.sv - self-checking bench for stage_wb with a reference model
module tb_stage_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  cmp_reg;
    logic [1:0]  scr;
    logic [31:0] sr_rdata;
    logic        exn;
    logic [31:0] exn_pc;
    logic        halted;

    always #5 clk = ~clk;

    mem_out_if mem_if ();

    stage_wb #(.EVEC_RST(32'h0000_0100), .SR_AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .MEM      (mem_if),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .cmp_reg  (cmp_reg),
        .scr      (scr),
        .sr_rdata (sr_rdata),
        .exn      (exn),
        .exn_pc   (exn_pc),
        .halted   (halted)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: 0 running, 1 in handler, 2 halted
    int          m_state;
    logic [31:0] m_sr [4];
    logic [1:0]  m_cmp;
    logic [1:0]  m_scr;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a < 4'd4) return m_sr[a[1:0]];
`ifdef BR32_PERF_CNT_EN
        if (a == 4'd4) return m_cyc;
        if (a == 4'd5) return m_ins;
`endif
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_sr[0] = 32'd0;
        m_sr[1] = 32'd0;
        m_sr[2] = 32'h0000_0100;
        m_sr[3] = 32'd0;
        m_cmp   = 2'd0;
        m_scr   = 2'd0;
        m_cyc   = 32'd0;
        m_ins   = 32'd0;
    endtask

    task automatic idle();
        mem_if.pc      = '0;
        mem_if.nextpc  = '0;
        mem_if.alu_res = '0;
        mem_if.op3     = '0;
        mem_if.res     = '0;
        mem_if.rd      = '0;
        mem_if.w_rd    = 1'b0;
        mem_if.cmp_res = '0;
        mem_if.w_cr    = 1'b0;
        mem_if.mtsr    = 1'b0;
        mem_if.scall   = 1'b0;
        mem_if.eret    = 1'b0;
        mem_if.udf     = 1'b0;
        mem_if.bubble  = 1'b0;
    endtask

    // compare the current cycle at negedge, then advance the model at posedge
    task automatic step();
        bit         halt, trp, eok, we;
        logic [3:0] a;
        @(negedge clk);
        halt = (m_state == 2);
        trp  = !halt && (mem_if.scall || mem_if.udf || (mem_if.eret && m_state == 0));
        eok  = (m_state == 1) && mem_if.eret && !mem_if.scall && !mem_if.udf;
        we   = !halt && !trp && mem_if.w_rd && (mem_if.rd != 0);
        a    = mem_if.alu_res[3:0];
        check("exn", exn, halt || trp || eok);
        if (halt || trp || eok)
            check("exn_pc", exn_pc, (m_state == 0) ? m_sr[2] : m_sr[0]);
        check("rf_we", rf_we, we);
        if (we) begin
            check("rf_waddr", rf_waddr, mem_if.rd);
            check("rf_wdata", rf_wdata, mem_if.res);
        end
        check("sr_rdata", sr_rdata, m_read(a));
        check("cmp_reg", cmp_reg, m_cmp);
        check("scr", scr, m_scr);
        check("halted", halted, m_state == 2);
        @(posedge clk);
        if (!halt) m_cyc++;
        if (!halt && !trp && !mem_if.bubble) m_ins++;
        if (trp) begin
            if (m_state == 0) begin
                m_sr[0] = mem_if.scall ? mem_if.nextpc : mem_if.pc;
                m_sr[1] = mem_if.scall ? 32'd1 : (mem_if.udf ? 32'd2 : 32'd3);
                m_scr   = m_cmp;
                m_state = 1;
            end else begin
                m_state = 2;
            end
        end else if (!halt) begin
            if (mem_if.w_cr) m_cmp = mem_if.cmp_res;
            if (mem_if.mtsr && (a == 0 || a == 2 || a == 3)) m_sr[a[1:0]] = mem_if.op3;
            if (eok) m_state = 0;
        end
        #1;
    endtask

    // asynchronous assert mid-cycle, release after one held edge
    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check("rst_halted", halted, 1'b0);
        check("rst_exn", exn, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_cmp_reg", cmp_reg, 2'd0);
        check("rst_scr", scr, 2'd0);
        mem_if.alu_res = 32'd2;
        #1;
        check("rst_evec", sr_rdata, 32'h0000_0100);
        idle();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int halt_cnt;
    int r, k;

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_halted", halted, 1'b0);
        check("reset_exn", exn, 1'b0);
        check("reset_rf_we", rf_we, 1'b0);
        rst = 1'b0;

        // ALU commit, then rd=0 suppression
        idle(); mem_if.w_rd = 1; mem_if.rd = 5'd5; mem_if.res = 32'h1234;
        #1;
        check("alu_we", rf_we, 1'b1);
        check("alu_waddr", rf_waddr, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234);
        step();
        mem_if.rd = 5'd0;
        #1;
        check("alu_rd0_we", rf_we, 1'b0);
        step();

        // scall with cmp_reg=2
        idle(); mem_if.w_cr = 1; mem_if.cmp_res = 2'd2;
        step();
        idle(); mem_if.scall = 1; mem_if.pc = 32'h40; mem_if.nextpc = 32'h44;
        mem_if.w_rd = 1; mem_if.rd = 5'd3; mem_if.res = 32'hdead;
        #1;
        check("scall_exn", exn, 1'b1);
        check("scall_exn_pc", exn_pc, 32'h100);
        check("scall_rf_we", rf_we, 1'b0);
        step();
        idle(); mem_if.alu_res = 32'd0;
        #1;
        check("scall_epc", sr_rdata, 32'h44);
        mem_if.alu_res = 32'd1;
        #1;
        check("scall_cause", sr_rdata, 32'd1);
        check("scall_scr", scr, 2'd2);
        // handler clobbers cmp_reg; eret must restore it
        mem_if.w_cr = 1; mem_if.cmp_res = 2'd1;
        step();

        // eret from handler restoring scr
        idle(); mem_if.eret = 1; mem_if.w_cr = 1; mem_if.cmp_res = 2'd2;
        #1;
        check("eret_exn", exn, 1'b1);
        check("eret_exn_pc", exn_pc, 32'h44);
        step();
        check("eret_cmp_reg", cmp_reg, 2'd2);

        // new vector, then udf
        idle(); mem_if.mtsr = 1; mem_if.alu_res = 32'd2; mem_if.op3 = 32'h200;
        step();
        idle(); mem_if.udf = 1; mem_if.pc = 32'h80; mem_if.w_cr = 1; mem_if.cmp_res = 2'd3;
        #1;
        check("udf_exn_pc", exn_pc, 32'h200);
        step();
        check("udf_no_cmp", cmp_reg, 2'd2);
        idle(); mem_if.alu_res = 32'd0;
        #1;
        check("udf_epc", sr_rdata, 32'h80);
        mem_if.alu_res = 32'd1;
        #1;
        check("udf_cause", sr_rdata, 32'd2);
        step();
        idle(); mem_if.mtsr = 1; mem_if.alu_res = 32'd1; mem_if.op3 = 32'hff;
        step();
        idle(); mem_if.alu_res = 32'd1;
        #1;
        check("cause_ro", sr_rdata, 32'd2);
        step();

        // double fault inside the handler
        idle(); mem_if.udf = 1; mem_if.pc = 32'hC0;
        step();
        check("df_halted", halted, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(); mem_if.alu_res = 32'(i & 1);
            mem_if.w_rd = 1; mem_if.rd = 5'd7;
            #1;
            check("halt_exn", exn, 1'b1);
            check("halt_exn_pc", exn_pc, 32'h80);
            check("halt_sr", sr_rdata, (i & 1) ? 32'd2 : 32'h80);
            step();
        end
        do_reset();

        // counters: 10 cycles, 4 bubbles
        for (int i = 0; i < 10; i++) begin
            idle(); mem_if.bubble = (i < 4);
            step();
        end
        idle(); mem_if.alu_res = 32'd4;
        #1;
`ifdef BR32_PERF_CNT_EN
        check("perf_cycle", sr_rdata, 32'd10);
        mem_if.alu_res = 32'd5;
        #1;
        check("perf_instret", sr_rdata, 32'd6);
`else
        check("noperf_sr4", sr_rdata, 32'd0);
`endif
        step();

        // randomized traffic against the model
        halt_cnt = 0;
        for (int n = 0; n < 2000; n++) begin
            idle();
            r = $urandom_range(0, 99);
            if (r < 15) begin
                mem_if.bubble = 1;
            end else begin
                mem_if.pc      = $urandom;
                mem_if.nextpc  = mem_if.pc + 32'd4;
                mem_if.alu_res = $urandom;
                mem_if.op3     = $urandom;
                mem_if.res     = $urandom;
                mem_if.rd      = 5'($urandom_range(0, 31));
                mem_if.cmp_res = 2'($urandom_range(0, 3));
                k = $urandom_range(0, 99);
                if (k < 60) begin
                    mem_if.w_rd = 1'($urandom_range(0, 1));
                    mem_if.w_cr = 1'($urandom_range(0, 1));
                end else if (k < 75) begin
                    mem_if.mtsr = 1;
                end else if (k < 82) begin
                    mem_if.scall = 1;
                    mem_if.w_rd  = 1'($urandom_range(0, 1));
                end else if (k < 88) begin
                    mem_if.udf  = 1;
                    mem_if.w_cr = 1'($urandom_range(0, 1));
                end else if (k < 96) begin
                    mem_if.eret    = 1;
                    mem_if.w_cr    = 1;
                    mem_if.cmp_res = m_scr;
                end
            end
            step();
            if (m_state == 2) halt_cnt++;
            if (halt_cnt >= 3) begin
                halt_cnt = 0;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
